// File: rtl/scan_sequencer_4to16.sv
// -----------------------------------------------------------------------------
// scan_sequencer_4to16
//   Walks the enabled channels of a 16-way decoder in ascending index order.
//   Each enabled channel is driven for D = max(dwell,1) cycles. Disabled
//   channels are skipped at no cycle cost. The scan runs either as a single
//   pass or continuously, until stop is asserted.
//
// Ports
//   clk       : single clock; all state updates on the rising edge
//   rst_n     : asynchronous active-low reset
//   start     : begin a scan (sampled in IDLE only)
//   stop      : abort a scan (sampled in SCAN only; takes priority)
//   one_shot  : 1 = single pass, 0 = continuous (sampled with start)
//   dwell     : cycles per channel; 0 behaves as 1 (sampled with start)
//   mask      : per-channel enable, bit i enables channel i (sampled with start)
//   sel_out   : channel index for the downstream 4-to-16 decoder
//   en_out    : decoder enable, high while a channel is being driven
//   busy      : high while scanning
//   done      : one-cycle pulse on completion, abort, or rejected start
//   wrap      : one-cycle pulse on the first cycle of every repeated pass
// -----------------------------------------------------------------------------
module scan_sequencer_4to16 #(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic               one_shot,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [15:0]        mask,
    output logic [3:0]         sel_out,
    output logic               en_out,
    output logic               busy,
    output logic               done,
    output logic               wrap
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    // Index of the lowest set bit; returns 0 for an all-zero vector.
    function automatic logic [3:0] lowest_set(input logic [15:0] m);
        logic [3:0] res;
        res = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (m[i]) begin
                res = 4'(i);
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // Counter reload value: D-1 where D = max(dwell,1).
    function automatic logic [DWELL_W-1:0] reload_val(input logic [DWELL_W-1:0] d);
        logic [DWELL_W-1:0] res;
        if (d == {DWELL_W{1'b0}}) begin
            res = {DWELL_W{1'b0}};
        end else begin
            res = d - DWELL_W'(1);
        end
        return res;
    endfunction

    state_t             state_r, state_s;
    logic [15:0]        mask_r, mask_s;
    logic [DWELL_W-1:0] reload_r, reload_s;
    logic               one_shot_r, one_shot_s;
    logic [DWELL_W-1:0] cnt_r, cnt_s;
    logic [3:0]         sel_r, sel_s;
    logic               en_r, en_s;
    logic               busy_r, busy_s;
    logic               done_r, done_s;
    logic               wrap_r, wrap_s;
    logic [15:0]        above_s;

    // Enabled channels strictly above the current one. For sel_r = 15 the
    // shifted term truncates to zero, so the expression yields an empty set.
    assign above_s = mask_r & ~((16'd2 << sel_r) - 16'd1);

    // Next-state and registered-output computation.
    always_comb begin
        state_s    = state_r;
        mask_s     = mask_r;
        reload_s   = reload_r;
        one_shot_s = one_shot_r;
        cnt_s      = cnt_r;
        sel_s      = sel_r;
        en_s       = en_r;
        busy_s     = busy_r;
        done_s     = 1'b0;
        wrap_s     = 1'b0;
        case (state_r)
            IDLE: begin
                en_s   = 1'b0;
                busy_s = 1'b0;
                if (start) begin
                    if (mask != 16'd0) begin
                        state_s    = SCAN;
                        mask_s     = mask;
                        reload_s   = reload_val(dwell);
                        one_shot_s = one_shot;
                        cnt_s      = reload_val(dwell);
                        sel_s      = lowest_set(mask);
                        en_s       = 1'b1;
                        busy_s     = 1'b1;
                    end else begin
                        // Nothing to scan: acknowledge and stay idle.
                        done_s = 1'b1;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            SCAN: begin
                if (stop) begin
                    // Abort wins over dwell expiry and wrap; sel holds.
                    state_s = IDLE;
                    en_s    = 1'b0;
                    busy_s  = 1'b0;
                    done_s  = 1'b1;
                end else if (cnt_r != {DWELL_W{1'b0}}) begin
                    cnt_s = cnt_r - DWELL_W'(1);
                end else if (above_s != 16'd0) begin
                    sel_s = lowest_set(above_s);
                    cnt_s = reload_r;
                end else if (one_shot_r) begin
                    state_s = IDLE;
                    en_s    = 1'b0;
                    busy_s  = 1'b0;
                    done_s  = 1'b1;
                end else begin
                    sel_s  = lowest_set(mask_r);
                    cnt_s  = reload_r;
                    wrap_s = 1'b1;
                end
            end
            default: begin
                state_s = IDLE;
                en_s    = 1'b0;
                busy_s  = 1'b0;
            end
        endcase
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            mask_r     <= 16'd0;
            reload_r   <= {DWELL_W{1'b0}};
            one_shot_r <= 1'b0;
            cnt_r      <= {DWELL_W{1'b0}};
            sel_r      <= 4'd0;
            en_r       <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            wrap_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            mask_r     <= mask_s;
            reload_r   <= reload_s;
            one_shot_r <= one_shot_s;
            cnt_r      <= cnt_s;
            sel_r      <= sel_s;
            en_r       <= en_s;
            busy_r     <= busy_s;
            done_r     <= done_s;
            wrap_r     <= wrap_s;
        end
    end

    assign sel_out = sel_r;
    assign en_out  = en_r;
    assign busy    = busy_r;
    assign done    = done_r;
    assign wrap    = wrap_r;

endmodule

// File: tb/tb_scan_sequencer_4to16.sv
// -----------------------------------------------------------------------------
// tb_scan_sequencer_4to16
//   Scoreboard bench. Each issued scan is translated into the full per-cycle
//   output trace from the channel list, dwell and mode with plain arithmetic.
//   A negedge monitor pops and compares one trace entry per cycle.
// -----------------------------------------------------------------------------
module tb_scan_sequencer_4to16;

    typedef struct packed {
        logic [3:0] sel;
        logic       en;
        logic       busy;
        logic       done;
        logic       wrap;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        stop;
    logic        one_shot;
    logic [7:0]  dwell;
    logic [15:0] mask;
    logic [3:0]  sel_out;
    logic        en_out;
    logic        busy;
    logic        done;
    logic        wrap;

    exp_t       exp_q[$];
    int         vectors = 0;
    int         miss    = 0;
    logic [3:0] last_sel = 4'd0;

    scan_sequencer_4to16 #(.DWELL_W(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .stop     (stop),
        .one_shot (one_shot),
        .dwell    (dwell),
        .mask     (mask),
        .sel_out  (sel_out),
        .en_out   (en_out),
        .busy     (busy),
        .done     (done),
        .wrap     (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [3:0] s, input logic e, input logic b,
                                input logic d, input logic w);
        exp_t r;
        r.sel = s; r.en = e; r.busy = b; r.done = d; r.wrap = w;
        return r;
    endfunction

    task automatic check(input string name, input exp_t act, input exp_t req);
        vectors++;
        if (act !== req) begin
            miss++;
            $display("FAIL %s: got sel=%0d en=%b busy=%b done=%b wrap=%b, expected sel=%0d en=%b busy=%b done=%b wrap=%b",
                     name, act.sel, act.en, act.busy, act.done, act.wrap,
                     req.sel, req.en, req.busy, req.done, req.wrap);
        end
    endtask

    // Monitor: one trace entry per cycle while a transaction is outstanding.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            check("trace", mk(sel_out, en_out, busy, done, wrap), exp_q.pop_front());
        end
    end

    task automatic wait_drain();
        int i;
        i = 0;
        while (exp_q.size() > 0 && i < 2000) begin
            @(negedge clk);
            i++;
        end
        if (exp_q.size() > 0) begin
            vectors++;
            miss++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // Issue one scan. stop_at > 0 asserts stop during that scan cycle.
    // During the scan, mask is driven with mid_mask (or random when mid_rand)
    // and the other configuration inputs and start are randomised.
    task automatic run_scan(input logic [15:0] m, input logic [7:0] d, input logic os,
                            input int stop_at, input logic [15:0] mid_mask,
                            input logic mid_rand);
        int chans[$];
        int dd, n, len, pass, off;
        for (int i = 0; i < 16; i++) begin
            if (m[i]) chans.push_back(i);
        end
        n   = chans.size();
        dd  = (d == 8'd0) ? 1 : int'(d);
        len = (n == 0) ? 0 : ((stop_at > 0) ? stop_at : n * dd);
        mask     = m;
        dwell    = d;
        one_shot = os;
        start    = 1'b1;
        stop     = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        start = 1'b0;
        stop  = 1'b0;
        for (int k = 0; k < len; k++) begin
            pass = k / (n * dd);
            off  = k % (n * dd);
            exp_q.push_back(mk(4'(chans[off / dd]), 1'b1, 1'b1, 1'b0,
                               (pass > 0 && off == 0) ? 1'b1 : 1'b0));
            last_sel = 4'(chans[off / dd]);
        end
        exp_q.push_back(mk(last_sel, 1'b0, 1'b0, 1'b1, 1'b0));
        exp_q.push_back(mk(last_sel, 1'b0, 1'b0, 1'b0, 1'b0));
        for (int k = 1; k <= len; k++) begin
            mask     = mid_rand ? 16'($urandom) : mid_mask;
            dwell    = 8'($urandom);
            one_shot = 1'($urandom);
            start    = 1'($urandom);
            stop     = (k == stop_at) ? 1'b1 : 1'b0;
            @(posedge clk); #1;
        end
        start = 1'b0;
        stop  = 1'b0;
        wait_drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] m;
        logic [7:0]  d;
        logic        os;
        int          n, sa;

        rst_n = 1'b0; start = 1'b0; stop = 1'b0; one_shot = 1'b0;
        dwell = 8'd0; mask = 16'd0;
        #3;
        check("reset_state", mk(sel_out, en_out, busy, done, wrap), mk(4'd0, 1'b0, 1'b0, 1'b0, 1'b0));
        #10;
        rst_n = 1'b1;
        @(negedge clk);

        // Stop in IDLE is ignored.
        stop = 1'b1;
        @(negedge clk);
        check("stop_in_idle", mk(sel_out, en_out, busy, done, wrap), mk(4'd0, 1'b0, 1'b0, 1'b0, 1'b0));
        stop = 1'b0;

        // Directed scenarios.
        run_scan(16'h0005, 8'd2, 1'b1, 0, 16'h0005, 1'b0);
        run_scan(16'h8001, 8'd0, 1'b0, 8, 16'h8001, 1'b0);
        run_scan(16'hFFFF, 8'd3, 1'b0, 17, 16'hFFFF, 1'b0);
        run_scan(16'h0000, 8'd2, 1'b1, 0, 16'h0000, 1'b0);
        run_scan(16'h000F, 8'd1, 1'b1, 0, 16'h00F0, 1'b0);
        run_scan(16'h0100, 8'd2, 1'b0, 9, 16'h0000, 1'b1);

        // Reset in the middle of a scan on channel 7.
        mask = 16'hFFFF; dwell = 8'd1; one_shot = 1'b0; start = 1'b1; stop = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 8; k++) exp_q.push_back(mk(4'(k), 1'b1, 1'b1, 1'b0, 1'b0));
        for (int k = 1; k < 8; k++) begin
            mask = 16'($urandom); dwell = 8'($urandom); one_shot = 1'($urandom);
            @(posedge clk); #1;
        end
        #5;
        rst_n = 1'b0;
        #1;
        check("async_reset", mk(sel_out, en_out, busy, done, wrap), mk(4'd0, 1'b0, 1'b0, 1'b0, 1'b0));
        exp_q.delete();
        last_sel = 4'd0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("in_reset", mk(sel_out, en_out, busy, done, wrap), mk(4'd0, 1'b0, 1'b0, 1'b0, 1'b0));
        end
        rst_n = 1'b1;
        run_scan(16'h0090, 8'd2, 1'b1, 0, 16'h0000, 1'b1);

        // Randomised scans.
        for (int t = 0; t < 30; t++) begin
            m = 16'($urandom);
            case ($urandom_range(0, 3))
                0: m = m & 16'($urandom) & 16'($urandom);
                1: m = 16'(1) << $urandom_range(0, 15);
                2: m = ($urandom_range(0, 3) == 0) ? 16'h0000 : m;
                default: m = m;
            endcase
            d  = 8'($urandom_range(0, 3));
            os = 1'($urandom);
            n  = $countones(m);
            if (n == 0) begin
                sa = 0;
            end else if (os) begin
                sa = ($urandom_range(0, 3) == 0) ? $urandom_range(1, n * ((d == 8'd0) ? 1 : int'(d))) : 0;
            end else begin
                sa = $urandom_range(1, 60);
            end
            run_scan(m, d, os, sa, 16'h0000, 1'b1);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miss);
        $finish;
    end

endmodule

// File: doc/scan_sequencer_4to16.md
SCAN_SEQUENCER_4TO16 -- requirements
Module: scan_sequencer_4to16

Interface
REQ-001 The block SHALL have parameter DWELL_W, default 8: width of the dwell input and the internal dwell counter.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port start, input, 1, request to begin a scan; sampled only in IDLE.
REQ-005 The block SHALL have port stop, input, 1, request to abort a scan; sampled only in SCAN.
REQ-006 The block SHALL have port one_shot, input, 1, scan mode: 1 means a single pass, 0 means continuous; sampled with start.
REQ-007 The block SHALL have port dwell, input, DWELL_W, cycles spent per channel; value 0 is treated as 1; sampled with start.
REQ-008 The block SHALL have port mask, input, 16, per-channel scan enable (bit i enables channel i); sampled with start.
REQ-009 The block SHALL have port sel_out, output, 4, channel index that drives the downstream 4-to-16 decoder select.
REQ-010 The block SHALL have port en_out, output, 1, decoder enable; high only while a channel is being driven.
REQ-011 The block SHALL have port busy, output, 1, high while in SCAN.
REQ-012 The block SHALL have port done, output, 1, one-cycle pulse on scan completion, abort, or a rejected start.
REQ-013 The block SHALL have port wrap, output, 1, one-cycle pulse on the first cycle of each new pass in continuous mode.

Function
REQ-014 The block SHALL implement a two-state FSM with states IDLE and SCAN; all outputs SHALL be registered.
REQ-015 In IDLE, start=1 with a nonzero mask SHALL latch mask, dwell and one_shot, and enter SCAN on the next edge.
REQ-016 On the first SCAN cycle, sel_out SHALL equal the lowest set bit index of the latched mask, and en_out and busy SHALL both be 1.
REQ-017 Each channel SHALL be driven for exactly D = max(dwell,1) consecutive cycles; sel_out SHALL then step to the next higher set bit with no gap cycle, keeping en_out=1.
REQ-018 Masked channels SHALL be skipped with zero cycle cost.
REQ-019 In one_shot mode, once the highest set channel completes its D cycles, the next cycle SHALL have en_out=0, busy=0, done=1, and the state SHALL be IDLE.
REQ-020 In continuous mode, sel_out SHALL wrap from the highest set channel to the lowest, and wrap=1 SHALL be asserted on the first cycle of the lowest channel; the first pass SHALL NOT assert wrap.
REQ-021 A single-bit mask in continuous mode SHALL hold sel_out constant and pulse wrap every D cycles.
REQ-022 In IDLE, start=1 with mask=0 SHALL keep the block in IDLE with en_out=0, and SHALL pulse done=1 on the next cycle.
REQ-023 In SCAN, stop=1 SHALL cause the next cycle to have en_out=0, busy=0, done=1, and the state SHALL be IDLE.
REQ-024 stop SHALL take priority over dwell expiry and wrap in the same cycle; in that case wrap SHALL NOT pulse.
REQ-025 start in SCAN and stop in IDLE SHALL be ignored.
REQ-026 When start and stop are both 1 in IDLE, start SHALL be honoured.
REQ-027 Changes to mask, dwell or one_shot during SCAN SHALL have no effect until the next start.
REQ-028 In IDLE, sel_out SHALL hold its last driven value.
REQ-029 The dwell counter SHALL count D-1 down to 0; it SHALL be reloaded on every channel change and SHALL never underflow.

Reset
REQ-030 rst_n=0 SHALL immediately, independent of clk, force IDLE with sel_out=0, en_out=0, busy=0, done=0, wrap=0, and clear all latched registers.
REQ-031 Reset asserted mid-scan SHALL abort the scan without a done pulse.
REQ-032 After rst_n deasserts, the first start SHALL be honoured on the first rising edge.

Verification
REQ-033 A bench SHALL cover: mask=16'h0005, dwell=2, one_shot=1, start pulse -> sel_out=0 for 2 cycles, then 2 for 2 cycles, then en_out=0 and done=1 for one cycle, then busy=0.
REQ-034 A bench SHALL cover: mask=16'h8001, dwell=0, one_shot=0 -> sel_out alternates 0,15,0,15 every cycle, with wrap=1 on each return to 0 after the first pass.
REQ-035 A bench SHALL cover: mask=16'hFFFF, dwell=3, continuous, stop asserted during channel 5 -> next cycle en_out=0, done=1, busy=0, and sel_out holds 5.
REQ-036 A bench SHALL cover: mask=0 with a start pulse -> en_out stays 0, done=1 for one cycle, busy never rises.
REQ-037 A bench SHALL cover: rst_n driven low mid-scan at channel 7 -> outputs clear without waiting for a clock edge, no done pulse, and a restart scans from the lowest set bit.
REQ-038 A bench SHALL cover: mask changed from 16'h000F to 16'h00F0 during SCAN -> the scan continues on channels 0-3 only until the next start.
